pe_row_scheduler: RTL
=====================

Name: pe_row_scheduler

Overview:
Clocked sequencer for one 1-D row-convolution PE (filter memory, ifmap memory, multiplier, adder, split, accumulator, internal control).
Per job it:
- streams filter words and ifmap words into the PE memories with incrementing addresses;
- issues start and supplies one psum_in word per output;
- collects the psum_out words and waits for done.
Sits between the row buffers/psum source upstream and the result collector downstream; all channels are valid/ready.

Parameters:
WIDTH, 8, data width of filter, ifmap and psum words
DEPTH_F, 3, filter taps loaded per job
ADDR_F, 2, filter address width
DEPTH_I, 5, ifmap words loaded per job
ADDR_I, 3, ifmap address width
NUM_OUT, DEPTH_I-DEPTH_F+1 (localparam, 3), psum outputs per job

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid / cmd_ready  in/out  1/1  job command handshake
cmd_reload_f  in  1  1 = reload filter for this job
cmd_psum_en  in  1  1 = take psum_in from psum source; 0 = send zeros
filt_valid / filt_ready / filt_data  in/out/in  1/1/WIDTH  filter word stream
ifm_valid / ifm_ready / ifm_data  in/out/in  1/1/WIDTH  ifmap word stream
psrc_valid / psrc_ready / psrc_data  in/out/in  1/1/WIDTH  upstream psum stream
pe_f_valid / pe_f_ready / pe_f_data / pe_f_addr  out/in/out/out  1/1/WIDTH/ADDR_F  PE filter write
pe_i_valid / pe_i_ready / pe_i_data / pe_i_addr  out/in/out/out  1/1/WIDTH/ADDR_I  PE ifmap write
pe_start_valid / pe_start_ready  out/in  1/1  PE start token
pe_pin_valid / pe_pin_ready / pe_pin_data  out/in/out  1/1/WIDTH  PE psum_in
pe_pout_valid / pe_pout_ready / pe_pout_data  in/out/in  1/1/WIDTH  PE psum_out
pe_done_valid / pe_done_ready  in/out  1/1  PE done token
res_valid / res_ready / res_data / res_last  out/in/out/out  1/1/WIDTH/1  result stream
busy  out  1  high in any state except IDLE
err_proto  out  1  sticky protocol error
job_cnt  out  16  completed jobs, wraps at 2^16

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all counters 0; filt_loaded=0; res_valid=0; err_proto=0; job_cnt=0.
  - All outputs deassert immediately on rst_n low, mid-job included; the job is discarded.
- A handshake occurs on any clock edge where valid and ready are both 1.
- IDLE:
  - cmd_ready=1. On cmd handshake, latch psum_en and compute do_load_f = cmd_reload_f OR NOT filt_loaded.
  - Go to LOAD_F if do_load_f, else LOAD_I.
- LOAD_F:
  - pe_f_valid=filt_valid, filt_ready=pe_f_ready (combinational pass-through); pe_f_data=filt_data; pe_f_addr=f_cnt.
  - f_cnt increments on each handshake. On the handshake with f_cnt==DEPTH_F-1: f_cnt<=0, filt_loaded<=1, go to LOAD_I.
- LOAD_I: same pass-through on the ifm/pe_i channels with i_cnt up to DEPTH_I-1, then go to START.
- START: pe_start_valid=1 until handshake, then go to RUN.
- RUN: three concurrent sub-activities, each with its own counter.
  - psum_in:
    - while pin_cnt<NUM_OUT, pe_pin_valid asserts.
    - psum_en=1: pass psrc through (psrc_ready=pe_pin_ready).
    - psum_en=0: pe_pin_data=0 and psrc_ready=0.
  - psum_out:
    - 1-entry output register; pe_pout_ready = NOT res_valid OR res_ready.
    - On capture: res_valid<=1, res_data<=word, res_last<=(pout_cnt==NUM_OUT-1), pout_cnt++.
    - res_valid holds until res_ready; words beyond NUM_OUT are not accepted.
  - done: pe_done_ready=1 in RUN; on done, done_seen<=1.
  - Exit to IDLE when done_seen AND pout_cnt==NUM_OUT AND pin_cnt==NUM_OUT, on the same edge or later. On exit: job_cnt++, clear all counters and done_seen.
  - The result register may still hold the last word on entry to IDLE; a new cmd is accepted anyway.
- pe_done_ready=1 in all states. A done outside RUN sets err_proto; the done is consumed and the state is unchanged.
- Outside its phase every valid/ready output is 0.
- No arithmetic on data; widths pass through unchanged.
- Simultaneous events: done and the last pout on the same edge both count; exit occurs on the next edge when all three conditions hold.

Decomposition:
- Package pe_sched_pkg holds:
  - enum state_t {IDLE, LOAD_F, LOAD_I, START, RUN};
  - default width/depth constants shared with the PE;
  - a function computing NUM_OUT.
- One sub-module, pe_sched_outreg: a 1-entry valid/ready output register with a last bit, used for the result path.

Test Plan:
1. Reset then cmd(reload_f=1, psum_en=0); filter 1,2,3; ifmap 1,2,3,4,5:
   - pe_f_addr 0,1,2 and pe_i_addr 0..4 in order; start issued once.
   - pe_pin_data=0 three times; PE returns 14,20,26 → res 14,20,26 with res_last on 26.
   - job_cnt=1, busy falls.
2. Second cmd(reload_f=0, psum_en=1), psrc 10,10,10 → no filter phase (state goes straight to LOAD_I); pe_pin_data 10,10,10 in order; job_cnt=2.
3. Hold res_ready=0 for 20 cycles during RUN → only one word buffered; pe_pout_ready=0; no word lost or duplicated after release.
4. pe_done asserted in IDLE → err_proto=1 and sticky; state stays IDLE; next job completes normally.
5. rst_n low mid-LOAD_I (i_cnt=2) → all valids 0 immediately. Following cmd with reload_f=0 still enters LOAD_F because filt_loaded was cleared.
6. pe_done arrives before the last pout word → no exit until pout_cnt=3; then IDLE and job_cnt increments once.

Source files
------------

// File: rtl/pe_row_scheduler_pkg.sv
// Shared types and constants for the row-convolution PE scheduler.
package pe_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_I,
        START,
        RUN
    } state_t;

    // Defaults matching the PE memories this scheduler feeds.
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH_F = 3;
    localparam int DEF_ADDR_F  = 2;
    localparam int DEF_DEPTH_I = 5;
    localparam int DEF_ADDR_I  = 3;

    // A valid 1-D convolution yields one output per filter position.
    function automatic int calc_num_out(input int depth_f, input int depth_i);
        return depth_i - depth_f + 1;
    endfunction

endpackage

// File: rtl/pe_row_scheduler_if.sv
// All valid/ready channels and status of the scheduler; master = scheduler side.
interface pe_row_scheduler_if
    import pe_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_F = DEF_ADDR_F,
    parameter int ADDR_I = DEF_ADDR_I
);
    logic              cmd_valid, cmd_ready, cmd_reload_f, cmd_psum_en;
    logic              filt_valid, filt_ready;
    logic [WIDTH-1:0]  filt_data;
    logic              ifm_valid, ifm_ready;
    logic [WIDTH-1:0]  ifm_data;
    logic              psrc_valid, psrc_ready;
    logic [WIDTH-1:0]  psrc_data;
    logic              pe_f_valid, pe_f_ready;
    logic [WIDTH-1:0]  pe_f_data;
    logic [ADDR_F-1:0] pe_f_addr;
    logic              pe_i_valid, pe_i_ready;
    logic [WIDTH-1:0]  pe_i_data;
    logic [ADDR_I-1:0] pe_i_addr;
    logic              pe_start_valid, pe_start_ready;
    logic              pe_pin_valid, pe_pin_ready;
    logic [WIDTH-1:0]  pe_pin_data;
    logic              pe_pout_valid, pe_pout_ready;
    logic [WIDTH-1:0]  pe_pout_data;
    logic              pe_done_valid, pe_done_ready;
    logic              res_valid, res_ready, res_last;
    logic [WIDTH-1:0]  res_data;
    logic              busy, err_proto;
    logic [15:0]       job_cnt;

    modport master (
        input  cmd_valid, cmd_reload_f, cmd_psum_en,
        output cmd_ready,
        input  filt_valid, filt_data, output filt_ready,
        input  ifm_valid, ifm_data, output ifm_ready,
        input  psrc_valid, psrc_data, output psrc_ready,
        output pe_f_valid, pe_f_data, pe_f_addr, input pe_f_ready,
        output pe_i_valid, pe_i_data, pe_i_addr, input pe_i_ready,
        output pe_start_valid, input pe_start_ready,
        output pe_pin_valid, pe_pin_data, input pe_pin_ready,
        input  pe_pout_valid, pe_pout_data, output pe_pout_ready,
        input  pe_done_valid, output pe_done_ready,
        output res_valid, res_data, res_last, input res_ready,
        output busy, err_proto, job_cnt
    );

    modport slave (
        output cmd_valid, cmd_reload_f, cmd_psum_en,
        input  cmd_ready,
        output filt_valid, filt_data, input filt_ready,
        output ifm_valid, ifm_data, input ifm_ready,
        output psrc_valid, psrc_data, input psrc_ready,
        input  pe_f_valid, pe_f_data, pe_f_addr, output pe_f_ready,
        input  pe_i_valid, pe_i_data, pe_i_addr, output pe_i_ready,
        input  pe_start_valid, output pe_start_ready,
        input  pe_pin_valid, pe_pin_data, output pe_pin_ready,
        output pe_pout_valid, pe_pout_data, input pe_pout_ready,
        output pe_done_valid, input pe_done_ready,
        input  res_valid, res_data, res_last, output res_ready,
        input  busy, err_proto, job_cnt
    );

endinterface

// File: rtl/pe_row_scheduler_outreg.sv
// One-entry valid/ready holding register with a last flag for the result stream.
module pe_sched_outreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    assign in_ready = !out_valid || out_ready;

    // Load a new word when empty or draining; otherwise hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_row_scheduler.sv
// Job sequencer for one row-convolution PE: load filter/ifmap, start, feed psums, collect results.
module pe_row_scheduler
    import pe_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH_F = DEF_DEPTH_F,
    parameter int ADDR_F  = DEF_ADDR_F,
    parameter int DEPTH_I = DEF_DEPTH_I,
    parameter int ADDR_I  = DEF_ADDR_I
) (
    input  logic               clk,
    input  logic               rst_n,
    pe_row_scheduler_if.master bus
);

    localparam int NUM_OUT = calc_num_out(DEPTH_F, DEPTH_I);
    localparam int CW      = $clog2(NUM_OUT + 1);
    localparam logic [CW-1:0]     OUT_ALL  = CW'(NUM_OUT);
    localparam logic [CW-1:0]     OUT_LAST = CW'(NUM_OUT - 1);
    localparam logic [ADDR_F-1:0] F_LAST   = ADDR_F'(DEPTH_F - 1);
    localparam logic [ADDR_I-1:0] I_LAST   = ADDR_I'(DEPTH_I - 1);

    state_t            state, next_state;
    logic [ADDR_F-1:0] f_cnt;
    logic [ADDR_I-1:0] i_cnt;
    logic [CW-1:0]     pin_cnt, pout_cnt;
    logic              done_seen, filt_loaded, psum_en;
    logic              err_q;
    logic [15:0]       job_q;
    logic              or_in_ready;

    logic cmd_hs, f_hs, i_hs, start_hs, pin_hs, pout_hs, run_exit;

    assign cmd_hs   = bus.cmd_valid && bus.cmd_ready;
    assign f_hs     = bus.pe_f_valid && bus.pe_f_ready;
    assign i_hs     = bus.pe_i_valid && bus.pe_i_ready;
    assign start_hs = bus.pe_start_valid && bus.pe_start_ready;
    assign pin_hs   = bus.pe_pin_valid && bus.pe_pin_ready;
    assign pout_hs  = bus.pe_pout_valid && bus.pe_pout_ready;
    assign run_exit = done_seen && (pout_cnt == OUT_ALL) && (pin_cnt == OUT_ALL);

    assign bus.pe_f_data     = bus.filt_data;
    assign bus.pe_f_addr     = f_cnt;
    assign bus.pe_i_data     = bus.ifm_data;
    assign bus.pe_i_addr     = i_cnt;
    assign bus.pe_done_ready = 1'b1;
    assign bus.busy          = (state != IDLE);
    assign bus.err_proto     = err_q;
    assign bus.job_cnt       = job_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Phase sequencing; filter load is skipped when the PE still holds a valid filter.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_hs) next_state = (bus.cmd_reload_f || !filt_loaded) ? LOAD_F : LOAD_I;
            LOAD_F:  if (f_hs && f_cnt == F_LAST) next_state = LOAD_I;
            LOAD_I:  if (i_hs && i_cnt == I_LAST) next_state = START;
            START:   if (start_hs) next_state = RUN;
            RUN:     if (run_exit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-phase handshake steering; everything outside its phase stays quiet.
    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.filt_ready     = 1'b0;
        bus.ifm_ready      = 1'b0;
        bus.psrc_ready     = 1'b0;
        bus.pe_f_valid     = 1'b0;
        bus.pe_i_valid     = 1'b0;
        bus.pe_start_valid = 1'b0;
        bus.pe_pin_valid   = 1'b0;
        bus.pe_pin_data    = '0;
        bus.pe_pout_ready  = 1'b0;
        case (state)
            IDLE:   bus.cmd_ready = 1'b1;
            LOAD_F: begin
                bus.pe_f_valid = bus.filt_valid;
                bus.filt_ready = bus.pe_f_ready;
            end
            LOAD_I: begin
                bus.pe_i_valid = bus.ifm_valid;
                bus.ifm_ready  = bus.pe_i_ready;
            end
            START:  bus.pe_start_valid = 1'b1;
            RUN: begin
                if (pin_cnt != OUT_ALL) begin
                    if (psum_en) begin
                        bus.pe_pin_valid = bus.psrc_valid;
                        bus.psrc_ready   = bus.pe_pin_ready;
                        bus.pe_pin_data  = bus.psrc_data;
                    end else begin
                        bus.pe_pin_valid = 1'b1;
                    end
                end
                bus.pe_pout_ready = (pout_cnt != OUT_ALL) && or_in_ready;
            end
            default: ;
        endcase
    end

    // Address/output counters, job flags and status; a done outside RUN is flagged, not acted on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt       <= '0;
            i_cnt       <= '0;
            pin_cnt     <= '0;
            pout_cnt    <= '0;
            done_seen   <= 1'b0;
            filt_loaded <= 1'b0;
            psum_en     <= 1'b0;
            err_q       <= 1'b0;
            job_q       <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_hs) psum_en <= bus.cmd_psum_en;
                LOAD_F: if (f_hs) begin
                    if (f_cnt == F_LAST) begin
                        f_cnt       <= '0;
                        filt_loaded <= 1'b1;
                    end else begin
                        f_cnt <= f_cnt + 1'b1;
                    end
                end
                LOAD_I: if (i_hs) i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
                RUN: begin
                    if (run_exit) begin
                        pin_cnt   <= '0;
                        pout_cnt  <= '0;
                        done_seen <= 1'b0;
                        job_q     <= job_q + 1'b1;
                    end else begin
                        if (pin_hs)            pin_cnt   <= pin_cnt + 1'b1;
                        if (pout_hs)           pout_cnt  <= pout_cnt + 1'b1;
                        if (bus.pe_done_valid) done_seen <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (bus.pe_done_valid && state != RUN) err_q <= 1'b1;
        end
    end

    pe_sched_outreg #(.WIDTH(WIDTH)) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pout_hs),
        .in_ready  (or_in_ready),
        .in_data   (bus.pe_pout_data),
        .in_last   (pout_cnt == OUT_LAST),
        .out_valid (bus.res_valid),
        .out_ready (bus.res_ready),
        .out_data  (bus.res_data),
        .out_last  (bus.res_last)
    );

endmodule
